// File: rtl/du_state_dumper_pkg.sv
// Shared definitions for the debug-unit state dumper: FSM states and stream framing constants.
package du_state_dumper_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      SEND_INT,
      REG_RD,
      REG_SEND,
      MEM_RD,
      MEM_SEND,
      FINISH
   } state_t;

   localparam logic [7:0]  HEADER     = 8'hD5;
   localparam int unsigned SNAP_BYTES = 43;
   localparam int unsigned N_REGS     = 32;

endpackage

// File: rtl/du_state_dumper_if.sv
// Bundle of request, register/memory read and UART TX FIFO signals for the state dumper.
interface du_state_dumper_if #(
   parameter int NB_REG   = 32,
   parameter int NB_R_INT = 341
);
   logic                i_start;
   logic [NB_R_INT-1:0] i_intf_data;
   logic [4:0]          o_reg_addr;
   logic [NB_REG-1:0]   i_reg_data;
   logic [7:0]          o_mem_addr;
   logic [NB_REG-1:0]   i_mem_data;
   logic [7:0]          o_tx_data;
   logic                o_tx_wr;
   logic                i_tx_full;
   logic                o_busy;
   logic                o_done;

   modport slave (
      input  i_start, i_intf_data, i_reg_data, i_mem_data, i_tx_full,
      output o_reg_addr, o_mem_addr, o_tx_data, o_tx_wr, o_busy, o_done
   );

   modport master (
      output i_start, i_intf_data, i_reg_data, i_mem_data, i_tx_full,
      input  o_reg_addr, o_mem_addr, o_tx_data, o_tx_wr, o_busy, o_done
   );
endinterface

// File: rtl/du_word_serializer.sv
// Splits a 32-bit word into four LSB-first bytes, advancing only when the TX FIFO has room.
module du_word_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] word,
   input  logic        tx_full,
   output logic [7:0]  tx_byte,
   output logic        ready,
   output logic        last
);
   logic [31:0] shreg;
   logic [1:0]  idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         idx   <= '0;
         ready <= 1'b0;
      end else if (load) begin
         shreg <= word;
         idx   <= '0;
         ready <= 1'b1;
      end else if (ready && !tx_full) begin
         shreg <= {8'h00, shreg[31:8]};
         idx   <= idx + 2'd1;
         if (idx == 2'd3)
            ready <= 1'b0;
      end
   end

   assign tx_byte = shreg[7:0];
   assign last    = ready && (idx == 2'd3);
endmodule

// File: rtl/du_state_dumper.sv
// Streams header, pipeline-latch snapshot, register file and data memory to the UART TX FIFO.
module du_state_dumper
   import du_state_dumper_pkg::*;
#(
   parameter int NB_REG      = 32,
   parameter int NB_R_INT    = 341,
   parameter int N_MEM_WORDS = 64
) (
   input  logic           i_du_clk,
   input  logic           i_du_reset,
   du_state_dumper_if.slave bus
);
   localparam int unsigned SNAP_W   = SNAP_BYTES * 8 + 8;
   localparam logic [5:0]  LAST_INT = 6'(SNAP_BYTES);
   localparam logic [4:0]  LAST_REG = 5'(N_REGS - 1);
   localparam logic [7:0]  LAST_MEM = 8'(N_MEM_WORDS - 1);

   state_t              state, state_next;
   logic [SNAP_W-1:0]   snap, snap_init;
   logic [5:0]          int_idx;
   logic [4:0]          reg_addr;
   logic [7:0]          mem_addr;
   logic [NB_REG-1:0]   ser_word;
   logic [7:0]          ser_byte;
   logic                ser_load, ser_ready, ser_last;
   logic                word_phase, sending, word_done;

   du_word_serializer u_ser (
      .clk     (i_du_clk),
      .rst     (i_du_reset),
      .load    (ser_load),
      .word    (ser_word),
      .tx_full (bus.i_tx_full),
      .tx_byte (ser_byte),
      .ready   (ser_ready),
      .last    (ser_last)
   );

   // The header byte rides below the snapshot so the whole preamble is one shift register.
   always_comb begin
      snap_init               = '0;
      snap_init[7:0]          = HEADER;
      snap_init[8 +: NB_R_INT] = bus.i_intf_data;
   end

   // First *_SEND cycle captures read data addressed in the preceding *_RD cycle.
   always_comb begin
      word_phase = (state == REG_SEND) || (state == MEM_SEND);
      ser_load   = word_phase && !ser_ready;
      ser_word   = (state == MEM_SEND) ? bus.i_mem_data : bus.i_reg_data;
      sending    = (state == SEND_INT) || (word_phase && ser_ready);
      word_done  = ser_last && !bus.i_tx_full;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (bus.i_start) state_next = SNAP;
         SNAP:     state_next = SEND_INT;
         SEND_INT: if (!bus.i_tx_full && int_idx == LAST_INT) state_next = REG_RD;
         REG_RD:   state_next = REG_SEND;
         REG_SEND: if (word_done) state_next = (reg_addr == LAST_REG) ? MEM_RD : REG_RD;
         MEM_RD:   state_next = MEM_SEND;
         MEM_SEND: if (word_done) state_next = (mem_addr == LAST_MEM) ? FINISH : MEM_RD;
         FINISH:   state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_du_clk) begin
      if (i_du_reset) state <= IDLE;
      else            state <= state_next;
   end

   always_ff @(posedge i_du_clk) begin
      if (i_du_reset) begin
         snap     <= '0;
         int_idx  <= '0;
         reg_addr <= '0;
         mem_addr <= '0;
      end else begin
         case (state)
            SNAP: begin
               snap     <= snap_init;
               int_idx  <= '0;
               reg_addr <= '0;
               mem_addr <= '0;
            end
            SEND_INT: if (!bus.i_tx_full) begin
               snap    <= {8'h00, snap[SNAP_W-1:8]};
               int_idx <= int_idx + 6'd1;
            end
            REG_SEND: if (word_done && reg_addr != LAST_REG) reg_addr <= reg_addr + 5'd1;
            MEM_SEND: if (word_done && mem_addr != LAST_MEM) mem_addr <= mem_addr + 8'd1;
            default: ;
         endcase
      end
   end

   // Reset gates the strobes combinationally so an abort emits nothing in its own cycle.
   assign bus.o_tx_wr    = sending && !bus.i_tx_full && !i_du_reset;
   assign bus.o_tx_data  = (state == SEND_INT) ? snap[7:0] : ser_byte;
   assign bus.o_busy     = (state != IDLE);
   assign bus.o_done     = (state == FINISH) && !i_du_reset;
   assign bus.o_reg_addr = reg_addr;
   assign bus.o_mem_addr = mem_addr;
endmodule
